// File: rtl/bus_arbiter_pkg.sv
// Shared encodings for the core memory bus arbiter: access sizes, request kinds,
// bus responses, arbiter state and owner codes.
package bus_arbiter_pkg;

    localparam int SIZE_W = 2;

    localparam logic [SIZE_W-1:0] SIZE_B = 2'b00;
    localparam logic [SIZE_W-1:0] SIZE_H = 2'b01;
    localparam logic [SIZE_W-1:0] SIZE_W32 = 2'b10;
    localparam logic [SIZE_W-1:0] SIZE_D = 2'b11;

    localparam logic REQ_READ  = 1'b0;
    localparam logic REQ_WRITE = 1'b1;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        ARB_IDLE     = 2'b00,
        ARB_IF_BUSY  = 2'b01,
        ARB_MEM_BUSY = 2'b10
    } arb_state_e;

    localparam logic [1:0] ARB_OWNER_NONE = 2'b00;
    localparam logic [1:0] ARB_OWNER_IF   = 2'b01;
    localparam logic [1:0] ARB_OWNER_MEM  = 2'b10;

endpackage

// File: rtl/bus_arb_perf.sv
// Free-running 64-bit performance counters for the bus arbiter: grants per
// requester and cycles in which a fetch is held off while MEM also wants the bus.
module bus_arb_perf (
    input  logic        clk,
    input  logic        rst,
    input  logic        ifGrant_i,
    input  logic        memGrant_i,
    input  logic        conflict_i,
    output logic [63:0] perf_if_grants_o,
    output logic [63:0] perf_mem_grants_o,
    output logic [63:0] perf_conflict_cycles_o
);

    logic [63:0] ifGrants_q;
    logic [63:0] memGrants_q;
    logic [63:0] conflictCycles_q;

    // Counters wrap naturally at 2^64.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ifGrants_q       <= '0;
            memGrants_q      <= '0;
            conflictCycles_q <= '0;
        end else begin
            if (ifGrant_i)  ifGrants_q       <= ifGrants_q + 64'd1;
            if (memGrant_i) memGrants_q      <= memGrants_q + 64'd1;
            if (conflict_i) conflictCycles_q <= conflictCycles_q + 64'd1;
        end
    end

    assign perf_if_grants_o       = ifGrants_q;
    assign perf_mem_grants_o      = memGrants_q;
    assign perf_conflict_cycles_o = conflictCycles_q;

endmodule

// File: rtl/bus_arbiter.sv
// Fixed-priority (MEM over IF) arbiter sharing the core memory bus between fetch
// and load/store. Optional counters are enabled with the BUS_ARB_PERF_EN macro.
module bus_arbiter
    import bus_arbiter_pkg::*;
#(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_valid_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    input  logic [1:0]        if_size_i,
    input  logic              if_req_i,
    output logic              if_ready_o,
    output logic [DATA_W-1:0] if_data_read_o,
    output logic [1:0]        if_resp_o,
    input  logic              mem_valid_i,
    input  logic [ADDR_W-1:0] mem_addr_i,
    input  logic [1:0]        mem_size_i,
    input  logic              mem_req_i,
    input  logic [DATA_W-1:0] mem_data_write_i,
    input  logic [7:0]        mem_strb_i,
    output logic              mem_ready_o,
    output logic [DATA_W-1:0] mem_data_read_o,
    output logic [1:0]        mem_resp_o,
    output logic              bus_valid_o,
    output logic [ADDR_W-1:0] bus_addr_o,
    output logic [1:0]        bus_size_o,
    output logic              bus_req_o,
    output logic [DATA_W-1:0] bus_data_write_o,
    output logic [7:0]        bus_strb_o,
    input  logic              bus_ready_i,
    input  logic [DATA_W-1:0] bus_data_read_i,
    input  logic [1:0]        bus_resp_i,
    output logic [1:0]        arb_owner_o
`ifdef BUS_ARB_PERF_EN
    ,
    output logic [63:0]       perf_if_grants_o,
    output logic [63:0]       perf_mem_grants_o,
    output logic [63:0]       perf_conflict_cycles_o
`endif
);

    arb_state_e        state_q, state_d;
    logic              ifGrant, memGrant;
    logic [ADDR_W-1:0] busAddr_q;
    logic [1:0]        busSize_q;
    logic              busReq_q;
    logic [DATA_W-1:0] busDataWrite_q;
    logic [7:0]        busStrb_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= ARB_IDLE;
        else      state_q <= state_d;
    end

    // Grant only from IDLE, so every completion is followed by one IDLE turnaround.
    always_comb begin
        state_d     = state_q;
        ifGrant     = 1'b0;
        memGrant    = 1'b0;
        bus_valid_o = 1'b0;
        arb_owner_o = ARB_OWNER_NONE;
        if_ready_o  = 1'b0;
        mem_ready_o = 1'b0;
        case (state_q)
            ARB_IDLE: begin
                if (mem_valid_i) begin
                    memGrant = 1'b1;
                    state_d  = ARB_MEM_BUSY;
                end else if (if_valid_i) begin
                    ifGrant = 1'b1;
                    state_d = ARB_IF_BUSY;
                end
            end
            ARB_IF_BUSY: begin
                bus_valid_o = 1'b1;
                arb_owner_o = ARB_OWNER_IF;
                if_ready_o  = bus_ready_i;
                if (bus_ready_i) state_d = ARB_IDLE;
            end
            ARB_MEM_BUSY: begin
                bus_valid_o = 1'b1;
                arb_owner_o = ARB_OWNER_MEM;
                mem_ready_o = bus_ready_i;
                if (bus_ready_i) state_d = ARB_IDLE;
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    // Fetches carry no store payload, so their data and strobes are latched as zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busAddr_q      <= '0;
            busSize_q      <= '0;
            busReq_q       <= 1'b0;
            busDataWrite_q <= '0;
            busStrb_q      <= '0;
        end else if (memGrant) begin
            busAddr_q      <= mem_addr_i;
            busSize_q      <= mem_size_i;
            busReq_q       <= mem_req_i;
            busDataWrite_q <= mem_data_write_i;
            busStrb_q      <= mem_strb_i;
        end else if (ifGrant) begin
            busAddr_q      <= if_addr_i;
            busSize_q      <= if_size_i;
            busReq_q       <= if_req_i;
            busDataWrite_q <= '0;
            busStrb_q      <= '0;
        end
    end

    assign bus_addr_o       = busAddr_q;
    assign bus_size_o       = busSize_q;
    assign bus_req_o        = busReq_q;
    assign bus_data_write_o = busDataWrite_q;
    assign bus_strb_o       = busStrb_q;

    assign if_data_read_o  = bus_data_read_i;
    assign if_resp_o       = bus_resp_i;
    assign mem_data_read_o = bus_data_read_i;
    assign mem_resp_o      = bus_resp_i;

`ifdef BUS_ARB_PERF_EN
    // With both valid, IF can never be the one granted, so every such cycle is a stall.
    bus_arb_perf uPerf (
        .clk                    (clk),
        .rst                    (rst),
        .ifGrant_i              (ifGrant),
        .memGrant_i             (memGrant),
        .conflict_i             (if_valid_i & mem_valid_i),
        .perf_if_grants_o       (perf_if_grants_o),
        .perf_mem_grants_o      (perf_mem_grants_o),
        .perf_conflict_cycles_o (perf_conflict_cycles_o)
    );
`endif

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed self-checking bench for bus_arbiter: fetch, priority, store latching,
// flush, mid-transaction reset, error forwarding and (optionally) perf counters.
module tb_bus_arbiter;
    import bus_arbiter_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_valid_i;
    logic [63:0] if_addr_i;
    logic [1:0]  if_size_i;
    logic        if_req_i;
    logic        if_ready_o;
    logic [63:0] if_data_read_o;
    logic [1:0]  if_resp_o;
    logic        mem_valid_i;
    logic [63:0] mem_addr_i;
    logic [1:0]  mem_size_i;
    logic        mem_req_i;
    logic [63:0] mem_data_write_i;
    logic [7:0]  mem_strb_i;
    logic        mem_ready_o;
    logic [63:0] mem_data_read_o;
    logic [1:0]  mem_resp_o;
    logic        bus_valid_o;
    logic [63:0] bus_addr_o;
    logic [1:0]  bus_size_o;
    logic        bus_req_o;
    logic [63:0] bus_data_write_o;
    logic [7:0]  bus_strb_o;
    logic        bus_ready_i;
    logic [63:0] bus_data_read_i;
    logic [1:0]  bus_resp_i;
    logic [1:0]  arb_owner_o;
`ifdef BUS_ARB_PERF_EN
    logic [63:0] perf_if_grants_o;
    logic [63:0] perf_mem_grants_o;
    logic [63:0] perf_conflict_cycles_o;
`endif

    int checks = 0;
    int passed = 0;

    always #5 clk = ~clk;

    bus_arbiter #(.ADDR_W(64), .DATA_W(64)) dut (
        .clk              (clk),
        .rst              (rst),
        .if_valid_i       (if_valid_i),
        .if_addr_i        (if_addr_i),
        .if_size_i        (if_size_i),
        .if_req_i         (if_req_i),
        .if_ready_o       (if_ready_o),
        .if_data_read_o   (if_data_read_o),
        .if_resp_o        (if_resp_o),
        .mem_valid_i      (mem_valid_i),
        .mem_addr_i       (mem_addr_i),
        .mem_size_i       (mem_size_i),
        .mem_req_i        (mem_req_i),
        .mem_data_write_i (mem_data_write_i),
        .mem_strb_i       (mem_strb_i),
        .mem_ready_o      (mem_ready_o),
        .mem_data_read_o  (mem_data_read_o),
        .mem_resp_o       (mem_resp_o),
        .bus_valid_o      (bus_valid_o),
        .bus_addr_o       (bus_addr_o),
        .bus_size_o       (bus_size_o),
        .bus_req_o        (bus_req_o),
        .bus_data_write_o (bus_data_write_o),
        .bus_strb_o       (bus_strb_o),
        .bus_ready_i      (bus_ready_i),
        .bus_data_read_i  (bus_data_read_i),
        .bus_resp_i       (bus_resp_i),
        .arb_owner_o      (arb_owner_o)
`ifdef BUS_ARB_PERF_EN
        ,
        .perf_if_grants_o       (perf_if_grants_o),
        .perf_mem_grants_o      (perf_mem_grants_o),
        .perf_conflict_cycles_o (perf_conflict_cycles_o)
`endif
    );

    task automatic clearInputs();
        if_valid_i       = 1'b0;
        if_addr_i        = '0;
        if_size_i        = SIZE_W32;
        if_req_i         = REQ_READ;
        mem_valid_i      = 1'b0;
        mem_addr_i       = '0;
        mem_size_i       = SIZE_D;
        mem_req_i        = REQ_READ;
        mem_data_write_i = '0;
        mem_strb_i       = '0;
        bus_ready_i      = 1'b0;
        bus_data_read_i  = '0;
        bus_resp_i       = RESP_OKAY;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        clearInputs();
        #3;
        checks++; if (bus_valid_o !== 1'b0) $display("FAIL rst_valid: got %b want 0", bus_valid_o); else passed++;
        checks++; if (arb_owner_o !== 2'b00) $display("FAIL rst_owner: got %b want 00", arb_owner_o); else passed++;
        checks++; if (bus_addr_o !== 64'h0 || bus_strb_o !== 8'h0) $display("FAIL rst_fields: got addr %h strb %h want 0", bus_addr_o, bus_strb_o); else passed++;
        checks++; if (if_ready_o !== 1'b0 || mem_ready_o !== 1'b0) $display("FAIL rst_ready: got if %b mem %b want 0", if_ready_o, mem_ready_o); else passed++;
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_if_fetch();
        @(negedge clk);
        if_valid_i = 1'b1;
        if_addr_i  = 64'h8000_0000;
        #1;
        checks++; if (arb_owner_o !== 2'b00 || bus_valid_o !== 1'b0) $display("FAIL fetch_idle: got owner %b valid %b want 00/0", arb_owner_o, bus_valid_o); else passed++;
        @(negedge clk); #1;
        checks++; if (arb_owner_o !== 2'b01 || bus_valid_o !== 1'b1) $display("FAIL fetch_grant: got owner %b valid %b want 01/1", arb_owner_o, bus_valid_o); else passed++;
        checks++; if (bus_addr_o !== 64'h8000_0000 || bus_req_o !== REQ_READ || bus_strb_o !== 8'h0) $display("FAIL fetch_fields: got addr %h req %b strb %h want 80000000/0/00", bus_addr_o, bus_req_o, bus_strb_o); else passed++;
        @(negedge clk); #1;
        checks++; if (if_ready_o !== 1'b0) $display("FAIL fetch_early_ready: got %b want 0", if_ready_o); else passed++;
        @(negedge clk);
        bus_ready_i     = 1'b1;
        bus_data_read_i = 64'h0000_0013;
        #1;
        checks++; if (if_ready_o !== 1'b1 || if_data_read_o !== 64'h13) $display("FAIL fetch_done: got ready %b data %h want 1/13", if_ready_o, if_data_read_o); else passed++;
        checks++; if (mem_ready_o !== 1'b0) $display("FAIL fetch_mem_ready: got %b want 0", mem_ready_o); else passed++;
        @(negedge clk);
        bus_ready_i = 1'b0;
        if_valid_i  = 1'b0;
        #1;
        checks++; if (arb_owner_o !== 2'b00 || bus_valid_o !== 1'b0 || if_ready_o !== 1'b0) $display("FAIL fetch_after: got owner %b valid %b ready %b want 00/0/0", arb_owner_o, bus_valid_o, if_ready_o); else passed++;
    endtask

    task automatic test_priority();
        @(negedge clk);
        if_valid_i  = 1'b1;
        if_addr_i   = 64'h8000_0004;
        mem_valid_i = 1'b1;
        mem_addr_i  = 64'h8000_1000;
        mem_req_i   = REQ_READ;
        @(negedge clk); #1;
        checks++; if (arb_owner_o !== 2'b10 || bus_addr_o !== 64'h8000_1000) $display("FAIL prio_mem_first: got owner %b addr %h want 10/80001000", arb_owner_o, bus_addr_o); else passed++;
        @(negedge clk);
        bus_ready_i = 1'b1;
        #1;
        checks++; if (mem_ready_o !== 1'b1 || if_ready_o !== 1'b0) $display("FAIL prio_mem_done: got mem %b if %b want 1/0", mem_ready_o, if_ready_o); else passed++;
        @(negedge clk);
        bus_ready_i = 1'b0;
        mem_valid_i = 1'b0;
        #1;
        checks++; if (arb_owner_o !== 2'b00 || bus_valid_o !== 1'b0) $display("FAIL prio_turnaround: got owner %b valid %b want 00/0", arb_owner_o, bus_valid_o); else passed++;
        @(negedge clk); #1;
        checks++; if (arb_owner_o !== 2'b01 || bus_addr_o !== 64'h8000_0004) $display("FAIL prio_if_second: got owner %b addr %h want 01/80000004", arb_owner_o, bus_addr_o); else passed++;
        @(negedge clk);
        bus_ready_i = 1'b1;
        #1;
        checks++; if (if_ready_o !== 1'b1 || mem_ready_o !== 1'b0) $display("FAIL prio_if_done: got if %b mem %b want 1/0", if_ready_o, mem_ready_o); else passed++;
        @(negedge clk);
        clearInputs();
    endtask

    task automatic test_store();
        @(negedge clk);
        mem_valid_i      = 1'b1;
        mem_addr_i       = 64'h8000_2000;
        mem_req_i        = REQ_WRITE;
        mem_data_write_i = 64'hDEAD_BEEF;
        mem_strb_i       = 8'h0F;
        @(negedge clk);
        mem_addr_i       = 64'h0;
        mem_data_write_i = 64'h0;
        mem_strb_i       = 8'hFF;
        #1;
        checks++; if (bus_addr_o !== 64'h8000_2000 || bus_req_o !== REQ_WRITE) $display("FAIL store_latch: got addr %h req %b want 80002000/1", bus_addr_o, bus_req_o); else passed++;
        checks++; if (bus_data_write_o !== 64'hDEAD_BEEF || bus_strb_o !== 8'h0F) $display("FAIL store_data: got data %h strb %h want deadbeef/0f", bus_data_write_o, bus_strb_o); else passed++;
        @(negedge clk); #1;
        checks++; if (bus_addr_o !== 64'h8000_2000 || bus_valid_o !== 1'b1) $display("FAIL store_hold: got addr %h valid %b want 80002000/1", bus_addr_o, bus_valid_o); else passed++;
        @(negedge clk);
        bus_ready_i = 1'b1;
        #1;
        checks++; if (mem_ready_o !== 1'b1) $display("FAIL store_done: got %b want 1", mem_ready_o); else passed++;
        @(negedge clk);
        clearInputs();
    endtask

    task automatic test_flush();
        @(negedge clk);
        if_valid_i = 1'b1;
        if_addr_i  = 64'h8000_0100;
        @(negedge clk);
        if_valid_i = 1'b0;
        #1;
        checks++; if (bus_valid_o !== 1'b1 || arb_owner_o !== 2'b01) $display("FAIL flush_hold: got valid %b owner %b want 1/01", bus_valid_o, arb_owner_o); else passed++;
        @(negedge clk); #1;
        checks++; if (bus_valid_o !== 1'b1 || if_ready_o !== 1'b0) $display("FAIL flush_wait: got valid %b ready %b want 1/0", bus_valid_o, if_ready_o); else passed++;
        @(negedge clk);
        bus_ready_i = 1'b1;
        #1;
        checks++; if (if_ready_o !== 1'b1) $display("FAIL flush_ready: got %b want 1", if_ready_o); else passed++;
        @(negedge clk);
        bus_ready_i = 1'b0;
        #1;
        checks++; if (bus_valid_o !== 1'b0 || arb_owner_o !== 2'b00 || if_ready_o !== 1'b0) $display("FAIL flush_idle: got valid %b owner %b ready %b want 0/00/0", bus_valid_o, arb_owner_o, if_ready_o); else passed++;
    endtask

    task automatic test_reset_mid_op();
        @(negedge clk);
        mem_valid_i = 1'b1;
        mem_addr_i  = 64'h8000_3000;
        @(negedge clk); #1;
        checks++; if (bus_valid_o !== 1'b1 || arb_owner_o !== 2'b10) $display("FAIL rmid_busy: got valid %b owner %b want 1/10", bus_valid_o, arb_owner_o); else passed++;
        #1;
        rst = 1'b0;
        #1;
        checks++; if (bus_valid_o !== 1'b0 || arb_owner_o !== 2'b00 || bus_addr_o !== 64'h0) $display("FAIL rmid_async: got valid %b owner %b addr %h want 0/00/0", bus_valid_o, arb_owner_o, bus_addr_o); else passed++;
        clearInputs();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        if_valid_i = 1'b1;
        if_addr_i  = 64'h8000_0200;
        @(negedge clk); #1;
        checks++; if (arb_owner_o !== 2'b01 || bus_addr_o !== 64'h8000_0200) $display("FAIL rmid_regrant: got owner %b addr %h want 01/80000200", arb_owner_o, bus_addr_o); else passed++;
        @(negedge clk);
        bus_ready_i = 1'b1;
        #1;
        checks++; if (if_ready_o !== 1'b1) $display("FAIL rmid_done: got %b want 1", if_ready_o); else passed++;
        @(negedge clk);
        clearInputs();
    endtask

    task automatic test_error_resp();
        @(negedge clk);
        mem_valid_i = 1'b1;
        mem_addr_i  = 64'hFFFF_0000;
        @(negedge clk);
        bus_ready_i     = 1'b1;
        bus_resp_i      = RESP_SLVERR;
        bus_data_read_i = 64'h1234_5678_9ABC_DEF0;
        #1;
        checks++; if (mem_ready_o !== 1'b1 || mem_resp_o !== 2'b10) $display("FAIL err_resp: got ready %b resp %b want 1/10", mem_ready_o, mem_resp_o); else passed++;
        checks++; if (mem_data_read_o !== 64'h1234_5678_9ABC_DEF0 || if_ready_o !== 1'b0) $display("FAIL err_data: got data %h if_ready %b want 123456789abcdef0/0", mem_data_read_o, if_ready_o); else passed++;
        @(negedge clk);
        clearInputs();
    endtask

`ifdef BUS_ARB_PERF_EN
    task automatic runIf(input logic [63:0] addr);
        @(negedge clk);
        if_valid_i = 1'b1;
        if_addr_i  = addr;
        @(negedge clk);
        bus_ready_i = 1'b1;
        @(negedge clk);
        clearInputs();
    endtask

    task automatic runMem(input logic [63:0] addr);
        @(negedge clk);
        mem_valid_i = 1'b1;
        mem_addr_i  = addr;
        @(negedge clk);
        bus_ready_i = 1'b1;
        @(negedge clk);
        clearInputs();
    endtask

    task automatic test_perf();
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++; if (perf_if_grants_o !== 64'd0 || perf_mem_grants_o !== 64'd0) $display("FAIL perf_reset: got if %0d mem %0d want 0/0", perf_if_grants_o, perf_mem_grants_o); else passed++;
        @(negedge clk);
        rst = 1'b1;
        runIf(64'h8000_0000);
        runMem(64'h8000_1000);
        runIf(64'h8000_0004);
        runMem(64'h8000_1008);
        runIf(64'h8000_0008);
        #1;
        checks++; if (perf_if_grants_o !== 64'd3 || perf_mem_grants_o !== 64'd2) $display("FAIL perf_grants: got if %0d mem %0d want 3/2", perf_if_grants_o, perf_mem_grants_o); else passed++;
        checks++; if (perf_conflict_cycles_o !== 64'd0) $display("FAIL perf_conflict: got %0d want 0", perf_conflict_cycles_o); else passed++;
    endtask
`endif

    initial begin
        test_reset();
        test_if_fetch();
        test_priority();
        test_store();
        test_flush();
        test_reset_mid_op();
        test_error_resp();
`ifdef BUS_ARB_PERF_EN
        test_perf();
`endif
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/bus_arbiter.md
Name: bus_arbiter

Overview:
Shares the single core memory bus between the instruction-fetch requester (if_top) and the load/store requester (mem stage). It holds the granted request stable on the downstream bus until completion, then routes the response back to the owner only. Fixed priority: MEM over IF, because MEM belongs to the older instruction and must never be blocked by a fetch. Sits between the pipeline stages and the bus bridge/SoC interface.

Parameters:
ADDR_W, 64, address width (matches INST_ADDR_BUS)
DATA_W, 64, data width (matches DATA_BUS)

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-low
if_valid_i  in  1  IF request; held with fields until ready or withdrawn
if_addr_i  in  ADDR_W  IF address
if_size_i  in  2  IF size (SIZE_W)
if_req_i  in  1  IF request kind (always REQ_READ)
if_ready_o  out  1  IF completion pulse
if_data_read_o  out  DATA_W  IF read data, valid with if_ready_o
if_resp_o  out  2  IF response, valid with if_ready_o
mem_valid_i  in  1  MEM request
mem_addr_i  in  ADDR_W  MEM address
mem_size_i  in  2  MEM size
mem_req_i  in  1  REQ_READ / REQ_WRITE
mem_data_write_i  in  DATA_W  store data
mem_strb_i  in  8  byte strobes
mem_ready_o  out  1  MEM completion pulse
mem_data_read_o  out  DATA_W  MEM load data
mem_resp_o  out  2  MEM response
bus_valid_o  out  1  downstream request valid
bus_addr_o  out  ADDR_W  latched address
bus_size_o  out  2  latched size
bus_req_o  out  1  latched kind
bus_data_write_o  out  DATA_W  latched store data
bus_strb_o  out  8  latched strobes
bus_ready_i  in  1  downstream completion pulse
bus_data_read_i  in  DATA_W  downstream read data
bus_resp_i  in  2  downstream response
arb_owner_o  out  2  00 none, 01 IF, 10 MEM

Behaviour:
- States: IDLE, IF_BUSY, MEM_BUSY; 2-bit register.
- Reset (rst low, async): state IDLE; all latched bus_* fields 0; bus_valid_o 0; arb_owner_o 00. Ready outputs 0 because they decode from state.
- IDLE: mem_valid_i -> latch MEM fields, go to MEM_BUSY. Else if_valid_i -> latch IF fields (strb 0, data_write 0), go to IF_BUSY. Both valid -> MEM wins; IF waits.
- BUSY: bus_valid_o = 1; bus_* driven only from latched registers, never from live inputs.
- Completion: bus_ready_i in X_BUSY -> x_ready_o = 1 for that cycle; x_data_read_o/x_resp_o pass through combinationally. Next state IDLE. The non-owner's ready is 0.
- Latency: request seen in cycle N in IDLE; bus_valid_o high in N+1; requester ready in the same cycle as bus_ready_i. After every completion there is one mandatory IDLE turnaround cycle.
- Data outputs toward both requesters may carry bus_data_read_i at all times. Only ready qualifies them.
- Withdrawn request (IF flush / dont_fetch drops if_valid_i while IF_BUSY): the bus transaction still completes and the ready pulse is still issued. The requester ignores it (valid & ready). There is no abort.
- Non-OKAY bus_resp_i is forwarded unchanged; no retry.
- Async reset mid-transaction drops bus_valid_o immediately. The downstream must tolerate this (only used at system reset).
- arb_owner_o: 01 in IF_BUSY, 10 in MEM_BUSY, else 00.

Optional Feature:
BUS_ARB_PERF_EN
- Defined: adds three 64-bit outputs, each reset to 0 and wrapping at 2^64:
  - perf_if_grants_o: +1 per IF grant.
  - perf_mem_grants_o: +1 per MEM grant.
  - perf_conflict_cycles_o: +1 each cycle with both valid and the arbiter not IDLE-granting IF (IF stalled by MEM or by a busy bus).
- Undefined: ports and logic absent; behaviour otherwise identical.

Decomposition:
- defines.v (shared header) holds: SIZE_B/H/W/D, REQ_READ/REQ_WRITE, RESP_OKAY and the error codes, ARB_IDLE/ARB_IF_BUSY/ARB_MEM_BUSY encodings, ARB_OWNER_* codes.
- The single natural sub-module is bus_arb_perf (the counters), instantiated only under BUS_ARB_PERF_EN.

Test Plan:
- IF-only fetch: if_valid_i=1 addr 0x80000000, bus_ready_i two cycles after grant with data 0x00000013 -> if_ready_o one pulse, if_data_read_o=0x13, owner 01 then 00, mem_ready_o never high.
- Simultaneous request: IF 0x80000004 and MEM read 0x80001000 both valid in IDLE -> MEM served first; one IDLE cycle; then IF is granted with bus_addr_o=0x80000004.
- Store: MEM write addr 0x80002000, data 0xDEADBEEF, strb 0x0F; mem_addr_i changed to 0 while busy -> bus_addr_o stays 0x80002000, bus_req_o=REQ_WRITE until bus_ready_i.
- Flush: if_valid_i dropped while IF_BUSY -> bus_valid_o stays 1 until bus_ready_i; if_ready_o pulses once; state returns to IDLE.
- Reset mid-op: rst low during MEM_BUSY -> bus_valid_o 0 and arb_owner_o 00 without waiting for a clock edge; after release, the first grant proceeds normally.
- Error/perf: bus_resp_i=2'b10 -> forwarded on mem_resp_o. With BUS_ARB_PERF_EN, after 3 IF and 2 MEM grants the counters read 3 and 2.
